dpd_lut_cfg_ctrl: RTL and testbench
===================================

# dpd_lut_cfg_ctrl

Sequencing controller for the configuration port of the DPD actuator LUT (`dpd_lut_v2`). It arbitrates between two requesters and drives the LUT's enc/wec/addrc/dinc strobes while absorbing the LUT's fixed read latency:
- a host single-access port (register reads/writes);
- a bulk-load stream (full or partial coefficient table refresh).

It sits between the AXI register/DMA side and the LUT in the same clock domain as LUT ports A/B.

## Interface
Parameters:
- `DATA_WIDTH`, 32: LUT word width.
- `ADDR_WIDTH`, 3: LUT address width; depth = 2**ADDR_WIDTH.
- `RD_LATENCY`, 2: cycles from lut_en (read) to valid lut_dout; legal 1..4.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock for all logic.
- `rst`  in  1  synchronous active-high reset.
- `cmd_valid`  in  1  host command valid.
- `cmd_ready`  out  1  host command accepted when valid && ready.
- `cmd_we`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_WIDTH  host address.
- `cmd_wdata`  in  DATA_WIDTH  host write data.
- `rsp_valid`  out  1  one-cycle pulse; rsp_rdata valid.
- `rsp_rdata`  out  DATA_WIDTH  read data, held until next response.
- `load_start`  in  1  start bulk load (sampled in IDLE only).
- `load_base`  in  ADDR_WIDTH  first bulk address.
- `load_len`  in  ADDR_WIDTH+1  number of words, 0..2**ADDR_WIDTH.
- `s_valid`  in  1  bulk data beat valid.
- `s_ready`  out  1  bulk data beat accepted when valid && ready.
- `s_data`  in  DATA_WIDTH  bulk data word.
- `load_done`  out  1  one-cycle pulse after last bulk write strobe.
- `load_err`  out  1  one-cycle pulse when load_start arrives while not IDLE.
- `busy`  out  1  high in any state other than IDLE.
- `lut_en`, `lut_we`  out  1 each  to LUT enc/wec.
- `lut_addr`  out  ADDR_WIDTH  to LUT addrc.
- `lut_din`  out  DATA_WIDTH  to LUT dinc.
- `lut_dout`  in  DATA_WIDTH  from LUT doutc.

## Operation
- States:
  - IDLE: cmd_ready=1.
  - WR: one cycle, strobe issued; returns to IDLE.
  - RD: strobe issued, then wait RD_LATENCY cycles; capture lut_dout; pulse rsp_valid; return to IDLE.
  - LOAD: s_ready=1 and cmd_ready=0; on remaining count reaching 0, go to DONE.
  - DONE: pulse load_done for one cycle; return to IDLE.
- Arbitration: only in IDLE. load_start wins over a simultaneous cmd_valid; the command stays pending (cmd_ready=0) and is served after DONE.
- load_len=0: IDLE -> DONE directly. No LUT strobes; load_done still pulses.
- Bulk addressing: word k goes to (load_base + k) mod 2**ADDR_WIDTH. Wrap-around is legal. load_len = 2**ADDR_WIDTH rewrites the whole table.
- load_start outside IDLE: ignored, load_err pulses, and the current operation is unaffected.
- lut_we is never high without lut_en.
- lut_addr/lut_din are driven to 0 whenever lut_en=0.
- Reset: all outputs 0 (including cmd_ready, s_ready, rsp_rdata) and state goes to IDLE. cmd_ready rises in the first cycle after rst deasserts.
- Reset during LOAD or RD aborts the operation: no further strobes, and no rsp_valid or load_done pulse.

## Timing
- All outputs are registered.
- Host write accepted in cycle T: lut_en=lut_we=1 in T+1; cmd_ready=0 in T+1 and 1 in T+2. Throughput is one write per 2 cycles.
- Host read accepted in cycle T: lut_en=1, lut_we=0 in T+1. lut_dout is sampled at the end of T+1+RD_LATENCY. rsp_valid is high in T+2+RD_LATENCY (T+4 for the default). cmd_ready returns the same cycle.
- Bulk load:
  - load_start in cycle T: s_ready=1 from T+1.
  - Each beat accepted in cycle B produces a write strobe in B+1.
  - Gapless s_valid gives 1 word/cycle.
  - s_ready drops in the cycle after the last beat is accepted.
  - load_done pulses one cycle after the last strobe.
- s_valid gaps produce no strobe (no bubble writes).

## Structure
- Package `dpd_lut_cfg_pkg`: state enum (IDLE, WR, RD, LOAD, DONE) and the RD_LATENCY bounds constant.
- Sub-module `dpd_lut_rd_pipe`: an RD_LATENCY-deep valid shift register that produces the capture strobe. Everything else is flat.

## Test plan
- Host write 0x3 <- 0x33333333, then read 0x3 -> lut_en/we high exactly one cycle; rsp_valid 3 cycles after the read strobe with rsp_rdata=0x33333333.
- Bulk load, base=0, len=8, data 0x11111111*k gapless -> 8 consecutive strobes at addresses 0..7; load_done one cycle after the addr-7 strobe; host reads of all 8 addresses match.
- Bulk load, base=6, len=4, s_valid toggling every other cycle -> writes to 6,7,0,1 only on accepted beats; no extra strobes.
- load_start and cmd_valid (read addr 2) in the same IDLE cycle, len=0 -> load_done pulses first with no strobes; the read is then served and returns the addr-2 contents.
- load_start during LOAD -> load_err pulses once; the original load completes normally.
- rst asserted after the 3rd of 8 bulk beats -> no strobes after reset; load_done never pulses; all outputs 0; cmd_ready=1 the cycle after release.

Source files
------------

// File: rtl/dpd_lut_cfg_pkg.sv
// Shared definitions for the DPD LUT configuration-port controller.
//   state_e             : controller FSM states (encoding also seen on dbg_state)
//   RD_LATENCY_MIN/MAX  : legal range of the LUT read latency parameter
package dpd_lut_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_LOAD = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 4;

endpackage

// File: rtl/dpd_lut_rd_pipe.sv
// Read-latency tracker: delays the read-strobe marker by RD_LATENCY cycles so
// the controller knows the cycle in which lut_dout carries the requested word.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset (drops any read in flight)
//   issue_i    : high in the cycle the LUT read strobe is on the port
//   capture_o  : high in the cycle lut_dout is valid for that read
module dpd_lut_rd_pipe
    import dpd_lut_cfg_pkg::*;
#(
    parameter int RD_LATENCY = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic issue_i,
    output logic capture_o
);

    if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
        $error("dpd_lut_rd_pipe: RD_LATENCY out of range");
    end

    logic [RD_LATENCY-1:0] pipe_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= issue_i;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign capture_o = pipe_q[RD_LATENCY-1];

endmodule

// File: rtl/dpd_lut_cfg_ctrl.sv
// Configuration-port sequencer for the DPD actuator LUT. Arbitrates between a
// host single-access port and a bulk-load stream and drives the LUT port-C
// strobes, absorbing the LUT read latency. All outputs are registered.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_we/
//   cmd_addr/cmd_wdata              : host command (valid/ready)
//   rsp_valid/rsp_rdata             : read response pulse, data held after
//   load_start/load_base/load_len   : bulk-load request (taken in IDLE only)
//   s_valid/s_ready/s_data          : bulk data stream (valid/ready)
//   load_done/load_err              : bulk completion / rejected-start pulses
//   busy                            : controller not in IDLE
//   lut_en/lut_we/lut_addr/lut_din  : LUT enc/wec/addrc/dinc
//   lut_dout                        : LUT doutc
//   dbg_state                       : current FSM state (state_e encoding)
// Handshakes: a transfer happens in a cycle where valid && ready are both high;
// valid may rise without waiting for ready, ready never depends on valid.
module dpd_lut_cfg_ctrl
    import dpd_lut_cfg_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH-1:0] load_base,
    input  logic [ADDR_WIDTH:0]   load_len,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  load_done,
    output logic                  load_err,
    output logic                  busy,
    output logic                  lut_en,
    output logic                  lut_we,
    output logic [ADDR_WIDTH-1:0] lut_addr,
    output logic [DATA_WIDTH-1:0] lut_din,
    input  logic [DATA_WIDTH-1:0] lut_dout,
    output logic [2:0]            dbg_state
);

    localparam int CNT_W = ADDR_WIDTH + 1;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  s_ready_q, s_ready_d;
    logic                  lut_en_q, lut_en_d;
    logic                  lut_we_q, lut_we_d;
    logic [ADDR_WIDTH-1:0] lut_addr_q, lut_addr_d;
    logic [DATA_WIDTH-1:0] lut_din_q, lut_din_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  load_done_q, load_done_d;
    logic                  load_err_q, load_err_d;
    logic                  busy_q;
    logic                  capture;

    // Marks the LUT read strobe as it leaves on the port; capture rises when
    // the matching word is on lut_dout.
    dpd_lut_rd_pipe #(
        .RD_LATENCY(RD_LATENCY)
    ) u_rd_pipe (
        .clk_i     (clk),
        .rst_i     (rst),
        .issue_i   (lut_en_q & ~lut_we_q),
        .capture_o (capture)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        cmd_ready_d = 1'b0;
        s_ready_d   = 1'b0;
        lut_en_d    = 1'b0;
        lut_we_d    = 1'b0;
        lut_addr_d  = '0;
        lut_din_d   = '0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        load_done_d = 1'b0;
        load_err_d  = load_start && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    // Bulk load wins; a simultaneous host command stays
                    // pending because cmd_ready drops until after DONE.
                    cnt_d = load_len;
                    ptr_d = load_base;
                    if (load_len == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_LOAD;
                        s_ready_d = 1'b1;
                    end
                end else if (cmd_valid && cmd_ready_q) begin
                    lut_en_d   = 1'b1;
                    lut_we_d   = cmd_we;
                    lut_addr_d = cmd_addr;
                    lut_din_d  = cmd_we ? cmd_wdata : '0;
                    state_d    = cmd_we ? ST_WR : ST_RD;
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end
            ST_WR: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
            end
            ST_RD: begin
                if (capture) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = lut_dout;
                    state_d     = ST_IDLE;
                    cmd_ready_d = 1'b1;
                end
            end
            ST_LOAD: begin
                s_ready_d = 1'b1;
                if (s_valid && s_ready_q) begin
                    lut_en_d   = 1'b1;
                    lut_we_d   = 1'b1;
                    lut_addr_d = ptr_q;
                    lut_din_d  = s_data;
                    // Pointer wraps naturally at the table depth.
                    ptr_d      = ptr_q + ADDR_WIDTH'(1);
                    cnt_d      = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d   = ST_DONE;
                        s_ready_d = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                load_done_d = 1'b1;
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ptr_q       <= '0;
            cmd_ready_q <= 1'b0;
            s_ready_q   <= 1'b0;
            lut_en_q    <= 1'b0;
            lut_we_q    <= 1'b0;
            lut_addr_q  <= '0;
            lut_din_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            cmd_ready_q <= cmd_ready_d;
            s_ready_q   <= s_ready_d;
            lut_en_q    <= lut_en_d;
            lut_we_q    <= lut_we_d;
            lut_addr_q  <= lut_addr_d;
            lut_din_q   <= lut_din_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign s_ready   = s_ready_q;
    assign lut_en    = lut_en_q;
    assign lut_we    = lut_we_q;
    assign lut_addr  = lut_addr_q;
    assign lut_din   = lut_din_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;
    assign busy      = busy_q;
    assign dbg_state = 3'(state_q);

endmodule

// File: tb/tb_dpd_lut_cfg_ctrl.sv
// Bench for dpd_lut_cfg_ctrl: a LUT model with fixed read latency on port C,
// directed host/bulk sequences, and a cycle-indexed schedule of expected port
// activity derived from the block's timing rules.
module tb_dpd_lut_cfg_ctrl;

  localparam int DW     = 32;
  localparam int AW     = 3;
  localparam int LW     = AW + 1;
  localparam int DEPTH  = 1 << AW;
  localparam int RD_LAT = 2;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } strobe_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          load_start;
  logic [AW-1:0] load_base;
  logic [LW-1:0] load_len;
  logic          s_valid, s_ready;
  logic [DW-1:0] s_data;
  logic          load_done, load_err, busy;
  logic          lut_en, lut_we;
  logic [AW-1:0] lut_addr;
  logic [DW-1:0] lut_din, lut_dout;
  logic [2:0]    dbg_state;

  dpd_lut_cfg_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .load_start(load_start), .load_base(load_base), .load_len(load_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .load_done(load_done), .load_err(load_err), .busy(busy),
    .lut_en(lut_en), .lut_we(lut_we), .lut_addr(lut_addr), .lut_din(lut_din),
    .lut_dout(lut_dout), .dbg_state(dbg_state)
  );

  // ---------------- LUT model (port C) ----------------
  logic [DW-1:0] lut_mem [DEPTH];
  logic [DW-1:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    if (lut_en && lut_we) lut_mem[lut_addr] <= lut_din;
    rd_pipe[0] <= lut_mem[lut_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign lut_dout = rd_pipe[RD_LAT-1];

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] exp_mem [DEPTH];
  strobe_t       exp_strobe [int];
  logic [DW-1:0] exp_rsp [int];
  bit            exp_done [int];
  bit            exp_err [int];

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  function automatic strobe_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    strobe_t s;
    s.we = we; s.addr = a; s.din = d;
    return s;
  endfunction

  // Per-cycle compare of all port-C and event outputs against the schedule.
  always @(negedge clk) begin : cmp
    strobe_t es;
    logic    e_en;
    if (chk_on) begin
      e_en = exp_strobe.exists(cyc) ? 1'b1 : 1'b0;
      es   = e_en ? exp_strobe[cyc] : '0;
      chk("lut_port", {lut_en, lut_we, lut_addr, lut_din}, {e_en, es.we, es.addr, es.din});
      chk("rsp_valid", rsp_valid, exp_rsp.exists(cyc) ? 1 : 0);
      if (rsp_valid && exp_rsp.exists(cyc)) chk("rsp_rdata", rsp_rdata, exp_rsp[cyc]);
      chk("load_done", load_done, exp_done.exists(cyc) ? 1 : 0);
      chk("load_err", load_err, exp_err.exists(cyc) ? 1 : 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!(cmd_ready === 1'b1 && busy === 1'b0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_timeout", 0, 1);
  endtask

  // Issues one host command; t_acc is the cycle the handshake completed.
  task automatic host(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, output int t_acc);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      chk("cmd_timeout", 0, 1);
      cmd_valid = 1'b0;
      t_acc = -1;
      return;
    end
    t_acc = cyc;
    if (we) begin
      exp_strobe[t_acc+1] = mk(1'b1, a, d);
      exp_mem[a] = d;
    end else begin
      exp_strobe[t_acc+1] = mk(1'b0, a, '0);
      exp_rsp[t_acc+2+RD_LAT] = exp_mem[a];
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Host read followed by a literal check of the response at accept+2+RD_LAT.
  task automatic read_lit(input logic [AW-1:0] a, input logic [DW-1:0] lit, input string name);
    int t;
    host(1'b0, a, '0, t);
    repeat (RD_LAT + 1) @(negedge clk);
    chk({name, "_valid"}, rsp_valid, 1);
    chk(name, rsp_rdata, lit);
  endtask

  // Bulk load; word k = mul*k + add. gap=1 drives s_valid every other cycle.
  // err_at injects a load_start in that load cycle; abort_after asserts rst
  // in the cycle after that many beats were accepted.
  task automatic do_load(input logic [AW-1:0] base, input int len, input logic [DW-1:0] mul,
                         input logic [DW-1:0] add, input int gap, input int err_at,
                         input int abort_after);
    int t0, k, i, c;
    logic v;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    wait_idle();
    t0 = cyc;
    load_start = 1'b1; load_base = base; load_len = LW'(len);
    if (len == 0) exp_done[t0+2] = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    k = 0; i = 0;
    while (k < len) begin
      c = cyc;
      chk("s_ready_load", s_ready, 1);
      if (i == err_at) begin
        load_start = 1'b1; load_base = 3'd5; load_len = LW'(2);
        exp_err[c+1] = 1'b1;
      end else begin
        load_start = 1'b0;
      end
      v = (gap == 0) || (i % 2 == 0);
      a = AW'(int'(base) + k);
      d = mul * DW'(k) + add;
      s_valid = v;
      s_data  = v ? d : '0;
      if (v) begin
        exp_strobe[c+1] = mk(1'b1, a, d);
        exp_mem[a] = d;
        k++;
        if (k == len && abort_after < 0) exp_done[c+2] = 1'b1;
      end
      i++;
      @(negedge clk);
      if (v && k == abort_after) begin
        s_valid = 1'b0; load_start = 1'b0; rst = 1'b1;
        return;
      end
    end
    s_valid = 1'b0; load_start = 1'b0;
    chk("s_ready_after", s_ready, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int t;
    for (int i = 0; i < DEPTH; i++) begin
      lut_mem[i] = '0;
      exp_mem[i] = '0;
    end
    for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = '0;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    load_start = 1'b0; load_base = '0; load_len = '0;
    s_valid = 1'b0; s_data = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    chk("rst_ctrl_zero", {cmd_ready, s_ready, rsp_valid, load_done, load_err, busy, lut_en, lut_we, lut_addr, dbg_state}, 0);
    chk("rst_data_zero", {rsp_rdata, lut_din}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);

    // Host write then read of address 3
    host(1'b1, 3'd3, 32'h3333_3333, t);
    chk("wr_ready_low", cmd_ready, 0);
    @(negedge clk);
    chk("wr_ready_high", cmd_ready, 1);
    read_lit(3'd3, 32'h3333_3333, "rd3");

    // Full-table gapless load, then read every address back
    do_load(3'd0, 8, 32'h1111_1111, 32'h0, 0, -1, -1);
    for (int a = 0; a < DEPTH; a++) host(1'b0, AW'(a), '0, t);
    repeat (RD_LAT + 1) @(negedge clk);
    chk("rd7_lit", rsp_rdata, 32'h7777_7777);

    // Wrapping partial load with s_valid gaps
    do_load(3'd6, 4, 32'h1, 32'hA000_0000, 1, -1, -1);
    read_lit(3'd0, 32'hA000_0002, "wrap_rd0");
    read_lit(3'd2, 32'h2222_2222, "wrap_rd2");
    host(1'b0, 3'd7, '0, t);
    host(1'b0, 3'd1, '0, t);

    // load_start (len 0) and host read of addr 2 in the same IDLE cycle
    wait_idle();
    t = cyc;
    load_start = 1'b1; load_base = 3'd4; load_len = '0;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 3'd2; cmd_wdata = '0;
    exp_done[t+2] = 1'b1;
    exp_strobe[t+3] = mk(1'b0, 3'd2, '0);
    exp_rsp[t+4+RD_LAT] = exp_mem[2];
    @(negedge clk);
    load_start = 1'b0;
    chk("z_ready_t1", cmd_ready, 0);
    @(negedge clk);
    chk("z_ready_t2", cmd_ready, 1);
    chk("z_done_t2", load_done, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (RD_LAT + 1) @(negedge clk);
    chk("z_rsp_valid", rsp_valid, 1);
    chk("z_rsp_rdata", rsp_rdata, 32'h2222_2222);

    // load_start during LOAD
    do_load(3'd0, 8, 32'h1, 32'h5A00_0000, 0, 2, -1);
    read_lit(3'd4, 32'h5A00_0004, "err_rd4");

    // Reset after the 3rd of 8 beats
    do_load(3'd0, 8, 32'h1, 32'hC000_0000, 0, -1, 3);
    @(negedge clk);
    chk("abort_ctrl_zero", {cmd_ready, s_ready, rsp_valid, load_done, load_err, busy, lut_en, lut_we, lut_addr, dbg_state}, 0);
    chk("abort_data_zero", {rsp_rdata, lut_din}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_cmd_ready", cmd_ready, 1);
    repeat (4) @(negedge clk);
    read_lit(3'd2, 32'hC000_0002, "abort_rd2");
    read_lit(3'd3, 32'h5A00_0003, "abort_rd3");
    host(1'b0, 3'd0, '0, t);
    host(1'b0, 3'd1, '0, t);

    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
